// File: rtl/spi_burst_feed_fsm.sv
// spi_burst_feed_fsm: feeds a counted burst of input-buffer words to an SPI master, one word per request edge
module spi_burst_feed_fsm #(
  parameter int BURST_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [BURST_W-1:0] i_burst_count,
  input  logic               i_spi_word_req,
  input  logic [BURST_W-1:0] i_inbuf_dat,
  output logic               o_busy,
  output logic               o_inbuf_re,
  output logic [BURST_W-1:0] o_inbuf_addr,
  output logic [BURST_W-1:0] o_spi_input_data,
  output logic               o_spi_data_valid,
  output logic               o_done
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_DATA, S_WAIT_REQ, S_DONE} state_t;
  localparam logic [BURST_W-1:0] ONE = 1;
  state_t             state;
  logic [2:0]         req_sync;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] cnt;
  logic [BURST_W-1:0] hold;
  logic               pending;
  logic               req_edge;
  assign req_edge = req_sync[1] & ~req_sync[2];
  // bring the asynchronous word request into the clock domain
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) req_sync <= '0;
    else req_sync <= {req_sync[1:0], i_spi_word_req};
  // burst sequencer; strobes default low so each assertion lasts one cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state            <= S_IDLE;
      burst            <= '0;
      cnt              <= '0;
      hold             <= '0;
      pending          <= 1'b0;
      o_busy           <= 1'b0;
      o_inbuf_re       <= 1'b0;
      o_inbuf_addr     <= '0;
      o_spi_input_data <= '0;
      o_spi_data_valid <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      o_inbuf_re       <= 1'b0;
      o_spi_data_valid <= 1'b0;
      o_done           <= 1'b0;
      case (state)
        S_IDLE: begin
          pending <= 1'b0;
          if (i_start) begin
            burst        <= i_burst_count;
            o_busy       <= 1'b1;
            o_inbuf_addr <= '0;
            state        <= (i_burst_count == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          o_inbuf_re <= 1'b1;
          if (req_edge) pending <= 1'b1;
          state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (req_edge) pending <= 1'b1;
          if (!o_inbuf_re) begin
            hold  <= i_inbuf_dat;
            state <= S_WAIT_REQ;
          end
        end
        S_WAIT_REQ: begin
          if (req_edge || pending) begin
            o_spi_input_data <= hold;
            o_spi_data_valid <= 1'b1;
            cnt              <= cnt + ONE;
            pending          <= 1'b0;
            if (cnt >= burst - ONE) state <= S_DONE;
            else begin
              o_inbuf_addr <= o_inbuf_addr + ONE;
              state        <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          o_done       <= 1'b1;
          o_busy       <= 1'b0;
          cnt          <= '0;
          o_inbuf_addr <= '0;
          pending      <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_burst_feed_fsm.sv
// tb_spi_burst_feed_fsm: randomized burst feeder bench against a buffer/word-queue reference model
module tb_spi_burst_feed_fsm;
  localparam int W = 16;
  logic         i_clk = 0, i_rst_n = 0, i_start = 0, i_spi_word_req = 0;
  logic [W-1:0] i_burst_count = '0, i_inbuf_dat;
  logic         o_busy, o_inbuf_re, o_spi_data_valid, o_done;
  logic [W-1:0] o_inbuf_addr, o_spi_input_data;
  logic [W-1:0] mem [256];
  logic [W-1:0] got_w[$];
  logic [W-1:0] got_a[$];
  int done_cnt = 0, busy_cyc = 0;
  int checks = 0, errors = 0;

  always #5 i_clk = ~i_clk;

  spi_burst_feed_fsm #(.BURST_W(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_burst_count(i_burst_count),
    .i_spi_word_req(i_spi_word_req), .i_inbuf_dat(i_inbuf_dat), .o_busy(o_busy),
    .o_inbuf_re(o_inbuf_re), .o_inbuf_addr(o_inbuf_addr), .o_spi_input_data(o_spi_input_data),
    .o_spi_data_valid(o_spi_data_valid), .o_done(o_done)
  );

  always @(posedge i_clk) if (o_inbuf_re) i_inbuf_dat <= mem[o_inbuf_addr[7:0]];

  always @(negedge i_clk) begin
    if (o_spi_data_valid) got_w.push_back(o_spi_input_data);
    if (o_inbuf_re) got_a.push_back(o_inbuf_addr);
    if (o_done) done_cnt++;
    if (o_busy) busy_cyc++;
  end

  task automatic clear_mon();
    @(posedge i_clk); #1;
    got_w.delete(); got_a.delete(); done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
  endtask

  task automatic start_burst(input int n);
    @(negedge i_clk); i_burst_count = W'(n); i_start = 1;
    @(negedge i_clk); i_start = 0;
  endtask

  task automatic drive_req(input int gap, input int budget, input int target, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      i_spi_word_req = (c % gap) < gap / 2;
      if (target > 0 ? got_w.size() >= target : done_cnt > 0) begin ok = 1; break; end
    end
    i_spi_word_req = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_busy, o_inbuf_re, o_spi_data_valid, o_done, o_inbuf_addr, o_spi_input_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b re=%b val=%b done=%b addr=%h data=%h, want all 0",
        o_busy, o_inbuf_re, o_spi_data_valid, o_done, o_inbuf_addr, o_spi_input_data);
    end
    i_rst_n = 1;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_busy, o_inbuf_re, o_spi_data_valid, o_done} !== '0) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b re=%b val=%b done=%b, want 0", o_busy, o_inbuf_re, o_spi_data_valid, o_done);
    end
  endtask

  task automatic test_latency();
    fill_mem(); clear_mon();
    @(negedge i_clk); i_burst_count = 1; i_start = 1;
    @(negedge i_clk); i_start = 0;
    checks++;
    if (o_busy !== 1 || o_inbuf_re !== 0) begin
      errors++; $display("FAIL start_latency_n: got busy=%b re=%b, want busy=1 re=0", o_busy, o_inbuf_re);
    end
    @(negedge i_clk);
    checks++;
    if (o_inbuf_re !== 1 || o_inbuf_addr !== 0) begin
      errors++; $display("FAIL read_strobe_n1: got re=%b addr=%h, want re=1 addr=0", o_inbuf_re, o_inbuf_addr);
    end
    repeat (2) @(negedge i_clk);
    i_spi_word_req = 1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_spi_data_valid !== 0) begin
      errors++; $display("FAIL req_latency_early: got valid=%b at T+1, want 0", o_spi_data_valid);
    end
    @(negedge i_clk);
    checks++;
    if (o_spi_data_valid !== 1 || o_spi_input_data !== mem[0]) begin
      errors++; $display("FAIL req_latency_t2: got valid=%b data=%h, want valid=1 data=%h", o_spi_data_valid, o_spi_input_data, mem[0]);
    end
    @(negedge i_clk);
    checks++;
    if (o_spi_data_valid !== 0 || o_done !== 1 || o_busy !== 0) begin
      errors++; $display("FAIL req_latency_t3: got valid=%b done=%b busy=%b, want 0,1,0", o_spi_data_valid, o_done, o_busy);
    end
    i_spi_word_req = 0;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic test_random_bursts();
    bit ok;
    for (int it = 0; it < 7; it++) begin
      int n, gap;
      fill_mem();
      if (it == 0) begin
        n = 4; gap = 20;
        for (int i = 0; i < 4; i++) mem[i] = W'(16'h1111 * (i + 1));
      end else begin
        n = $urandom_range(1, 12); gap = $urandom_range(8, 24);
      end
      clear_mon();
      start_burst(n);
      drive_req(gap, n * (gap + 12) + 60, 0, ok);
      drive_req(gap, 3 * gap, 1000, ok);
      checks++;
      if (got_w.size() != n || got_a.size() != n || done_cnt != 1) begin
        errors++; $display("FAIL burst_counts[%0d]: got words=%0d reads=%0d done=%0d, want %0d,%0d,1", it, got_w.size(), got_a.size(), done_cnt, n, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got_w[i] !== mem[i] || got_a[i] !== W'(i)) begin
            errors++; $display("FAIL burst_word[%0d][%0d]: got data=%h addr=%h, want data=%h addr=%h", it, i, got_w[i], got_a[i], mem[i], W'(i));
          end
        end
      end
    end
  endtask

  task automatic test_zero_burst();
    clear_mon();
    start_burst(0);
    repeat (6) @(negedge i_clk);
    checks++;
    if (done_cnt != 1 || got_a.size() != 0 || got_w.size() != 0 || busy_cyc != 1) begin
      errors++; $display("FAIL zero_burst: got done=%0d reads=%0d valids=%0d busy_cycles=%0d, want 1,0,0,1", done_cnt, got_a.size(), got_w.size(), busy_cyc);
    end
  endtask

  task automatic test_pending();
    int c;
    fill_mem(); clear_mon();
    start_burst(3);
    i_spi_word_req = 1; repeat (2) @(negedge i_clk); i_spi_word_req = 0;
    for (c = 0; c < 60 && got_w.size() < 1; c++) @(negedge i_clk);
    i_spi_word_req = 1; repeat (2) @(negedge i_clk); i_spi_word_req = 0;
    for (c = 0; c < 60 && got_w.size() < 2; c++) @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    i_spi_word_req = 1; repeat (2) @(negedge i_clk); i_spi_word_req = 0;
    for (c = 0; c < 60 && done_cnt == 0; c++) @(negedge i_clk);
    checks++;
    if (got_w.size() != 3 || done_cnt != 1) begin
      errors++; $display("FAIL pending_count: got words=%0d done=%0d, want 3,1", got_w.size(), done_cnt);
    end else begin
      checks++;
      if (got_w[0] !== mem[0] || got_w[1] !== mem[1] || got_w[2] !== mem[2]) begin
        errors++; $display("FAIL pending_words: got %h %h %h, want %h %h %h", got_w[0], got_w[1], got_w[2], mem[0], mem[1], mem[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_mem(); clear_mon();
    start_burst(8);
    drive_req(10, 200, 3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_reach3: got words=%0d, want 3", got_w.size()); end
    i_rst_n = 0; #1;
    checks++;
    if ({o_busy, o_inbuf_re, o_spi_data_valid, o_done, o_inbuf_addr, o_spi_input_data} !== '0) begin
      errors++; $display("FAIL reset_mid_async: got busy=%b re=%b val=%b addr=%h data=%h, want all 0", o_busy, o_inbuf_re, o_spi_data_valid, o_inbuf_addr, o_spi_input_data);
    end
    repeat (2) @(negedge i_clk); i_rst_n = 1;
    clear_mon();
    drive_req(10, 60, 1000, ok);
    checks++;
    if (got_w.size() != 0 || got_a.size() != 0 || done_cnt != 0) begin
      errors++; $display("FAIL reset_mid_quiet: got words=%0d reads=%0d done=%0d, want 0,0,0", got_w.size(), got_a.size(), done_cnt);
    end
    clear_mon();
    start_burst(2);
    drive_req(10, 100, 0, ok);
    checks++;
    if (got_a.size() != 2 || got_w.size() != 2 || got_a[0] !== 0 || got_a[1] !== 1 || got_w[0] !== mem[0] || got_w[1] !== mem[1]) begin
      errors++; $display("FAIL reset_mid_restart: got reads=%0d words=%0d, want addresses 0,1 with words %h %h", got_a.size(), got_w.size(), mem[0], mem[1]);
    end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    fill_mem(); clear_mon();
    start_burst(5);
    drive_req(12, 200, 2, ok);
    start_burst(1);
    drive_req(12, 300, 0, ok);
    checks++;
    if (got_w.size() != 5 || done_cnt != 1) begin
      errors++; $display("FAIL restart_ignored: got words=%0d done=%0d, want 5,1", got_w.size(), done_cnt);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_w[i] !== mem[i] || got_a[i] !== W'(i)) begin
          errors++; $display("FAIL restart_word[%0d]: got data=%h addr=%h, want data=%h addr=%h", i, got_w[i], got_a[i], mem[i], W'(i));
        end
      end
    end
  endtask

  task automatic test_held_req();
    fill_mem(); clear_mon();
    start_burst(2);
    i_spi_word_req = 1;
    repeat (40) @(negedge i_clk);
    checks++;
    if (got_w.size() != 1 || done_cnt != 0) begin
      errors++; $display("FAIL held_single: got words=%0d done=%0d, want 1,0", got_w.size(), done_cnt);
    end else begin
      checks++;
      if (got_w[0] !== mem[0]) begin errors++; $display("FAIL held_word0: got %h, want %h", got_w[0], mem[0]); end
    end
    i_spi_word_req = 0; repeat (3) @(negedge i_clk); i_spi_word_req = 1;
    for (int c = 0; c < 20 && done_cnt == 0; c++) @(negedge i_clk);
    i_spi_word_req = 0;
    checks++;
    if (got_w.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL held_second: got words=%0d done=%0d, want 2,1", got_w.size(), done_cnt);
    end else begin
      checks++;
      if (got_w[1] !== mem[1]) begin errors++; $display("FAIL held_word1: got %h, want %h", got_w[1], mem[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_random_bursts();
    test_zero_burst();
    test_pending();
    test_reset_mid();
    test_restart_ignored();
    test_held_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
